// File: rtl/decode_pkg.sv
`default_nettype none
//==== decode_pkg: opcodes, ALU encodings, imm types and decode helpers (rev 1.0) ====
package decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_J    = 3'd4,
    IMM_U    = 3'd5
  } imm_type_e;

  typedef struct packed {
    logic      known;
    imm_type_e imm_type;
    logic [3:0] alu_ctrl;
    logic      alu_src;
    logic      result_src;
    logic      mem_write;
    logic      reg_write;
    logic      branch;
    logic      jump;
    logic      jret;
    logic      use_rs1;
    logic      use_rs2;
    logic      use_rd;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [6:0] opcode,
                                        input logic [2:0] funct3,
                                        input logic       bit30);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_R: begin
        c.known = 1'b1; c.alu_ctrl = {bit30, funct3}; c.reg_write = 1'b1;
        c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; c.use_rd = 1'b1;
      end
      OP_IALU: begin
        c.known = 1'b1; c.imm_type = IMM_I; c.alu_src = 1'b1; c.reg_write = 1'b1;
        // only the shift-right group distinguishes logical/arithmetic via bit 30
        c.alu_ctrl = (funct3 == 3'b101) ? {bit30, funct3} : {1'b0, funct3};
        c.use_rs1 = 1'b1; c.use_rd = 1'b1;
      end
      OP_LOAD: begin
        c.known = 1'b1; c.imm_type = IMM_I; c.alu_ctrl = ALU_ADD; c.alu_src = 1'b1;
        c.result_src = 1'b1; c.reg_write = 1'b1; c.use_rs1 = 1'b1; c.use_rd = 1'b1;
      end
      OP_STORE: begin
        c.known = 1'b1; c.imm_type = IMM_S; c.alu_ctrl = ALU_ADD; c.alu_src = 1'b1;
        c.mem_write = 1'b1; c.use_rs1 = 1'b1; c.use_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        c.known = 1'b1; c.imm_type = IMM_B; c.alu_ctrl = ALU_SUB; c.branch = 1'b1;
        c.use_rs1 = 1'b1; c.use_rs2 = 1'b1;
      end
      OP_JAL: begin
        c.known = 1'b1; c.imm_type = IMM_J; c.alu_ctrl = ALU_ADD; c.alu_src = 1'b1;
        c.reg_write = 1'b1; c.jump = 1'b1; c.use_rd = 1'b1;
      end
      OP_JALR: begin
        c.known = 1'b1; c.imm_type = IMM_I; c.alu_ctrl = ALU_ADD; c.alu_src = 1'b1;
        c.reg_write = 1'b1; c.jret = 1'b1; c.use_rs1 = 1'b1; c.use_rd = 1'b1;
      end
      OP_LUI: begin
        c.known = 1'b1; c.imm_type = IMM_U; c.alu_ctrl = ALU_ADD; c.alu_src = 1'b1;
        c.reg_write = 1'b1; c.use_rd = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] gen_imm(input imm_type_e t, input logic [31:7] ins);
    logic [31:0] v;
    case (t)
      IMM_I:   v = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_J:   v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      IMM_U:   v = {ins[31:12], 12'h000};
      default: v = 32'h0;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_regfile.sv
`default_nettype none
//==== decode_regfile: register file with writeback-to-read bypass (rev 1.0) ====
module decode_regfile
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_W     = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     raddr1,
  input  logic [ADDR_W-1:0]     raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2,
  input  logic                  wb_en,
  input  logic [ADDR_W-1:0]     wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wr_fire,
  output logic [DATA_WIDTH-1:0] a0
);

  localparam int               IDX_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W:0]  LIMIT = (ADDR_W+1)'(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  assign wr_fire = wb_en && (wb_addr != '0) && ({1'b0, wb_addr} < LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_fire) begin
      regs[wb_addr[IDX_W-1:0]] <= wb_data;
    end
  end

  // out-of-range reads return 0; the decoder flags them illegal anyway
  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_W-1:0] a);
    logic [DATA_WIDTH-1:0] v;
    if (a == '0 || !({1'b0, a} < LIMIT)) v = '0;
    else if (wr_fire && wb_addr == a)    v = wb_data;
    else                                 v = regs[a[IDX_W-1:0]];
    return v;
  endfunction

  always_comb begin
    rdata1 = read_port(raddr1);
    rdata2 = read_port(raddr2);
  end

  assign a0 = regs[10];

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
//==== decode_stage: RV32 subset decoder with registered output stage (rev 1.0) ====
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_W     = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  flush_i,
  input  logic                  wb_en_i,
  input  logic [ADDR_W-1:0]     wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] rd1_o,
  output logic [DATA_WIDTH-1:0] rd2_o,
  output logic [DATA_WIDTH-1:0] imm_o,
  output logic [ADDR_W-1:0]     rd_addr_o,
  output logic [3:0]            alu_ctrl_o,
  output logic                  alu_src_o,
  output logic                  result_src_o,
  output logic                  mem_write_o,
  output logic                  reg_write_o,
  output logic                  branch_o,
  output logic                  jump_o,
  output logic                  jret_o,
  output logic                  illegal_o,
  output logic [DATA_WIDTH-1:0] a0_o
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_REGS);

  logic [ADDR_W-1:0]     rs1, rs2, rd;
  ctrl_t                 ctrl;
  logic                  range_bad, illegal;
  logic [DATA_WIDTH-1:0] imm, rdata1, rdata2;
  logic                  wr_fire, transfer;
  logic [ADDR_W-1:0]     held_rs1, held_rs2;
  logic                  held_use_rs1, held_use_rs2;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < LIMIT;
  endfunction

  assign rs1  = ADDR_W'(instr_i[19:15]);
  assign rs2  = ADDR_W'(instr_i[24:20]);
  assign rd   = ADDR_W'(instr_i[11:7]);
  assign ctrl = decode_ctrl(instr_i[6:0], instr_i[14:12], instr_i[30]);

  assign range_bad = (ctrl.use_rs1 && !in_range(rs1)) ||
                     (ctrl.use_rs2 && !in_range(rs2)) ||
                     (ctrl.use_rd  && !in_range(rd));
  assign illegal   = !ctrl.known || range_bad;
  assign imm       = DATA_WIDTH'($signed(gen_imm(ctrl.imm_type, instr_i[31:7])));

  assign in_ready = !flush_i && (!out_valid || out_ready);
  assign transfer = in_valid && in_ready;

  decode_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ADDR_W     (ADDR_W)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr1  (rs1),
    .raddr2  (rs2),
    .rdata1  (rdata1),
    .rdata2  (rdata2),
    .wb_en   (wb_en_i),
    .wb_addr (wb_addr_i),
    .wb_data (wb_data_i),
    .wr_fire (wr_fire),
    .a0      (a0_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      pc_o         <= '0;
      rd1_o        <= '0;
      rd2_o        <= '0;
      imm_o        <= '0;
      rd_addr_o    <= '0;
      alu_ctrl_o   <= '0;
      alu_src_o    <= 1'b0;
      result_src_o <= 1'b0;
      mem_write_o  <= 1'b0;
      reg_write_o  <= 1'b0;
      branch_o     <= 1'b0;
      jump_o       <= 1'b0;
      jret_o       <= 1'b0;
      illegal_o    <= 1'b0;
      held_rs1     <= '0;
      held_rs2     <= '0;
      held_use_rs1 <= 1'b0;
      held_use_rs2 <= 1'b0;
    end else if (flush_i) begin
      out_valid <= 1'b0;
    end else if (transfer) begin
      out_valid    <= 1'b1;
      pc_o         <= pc_i;
      rd1_o        <= rdata1;
      rd2_o        <= rdata2;
      imm_o        <= imm;
      rd_addr_o    <= rd;
      alu_ctrl_o   <= ctrl.alu_ctrl;
      alu_src_o    <= ctrl.alu_src;
      result_src_o <= ctrl.result_src;
      mem_write_o  <= ctrl.mem_write && !illegal;
      reg_write_o  <= ctrl.reg_write && !illegal;
      branch_o     <= ctrl.branch;
      jump_o       <= ctrl.jump;
      jret_o       <= ctrl.jret;
      illegal_o    <= illegal;
      held_rs1     <= rs1;
      held_rs2     <= rs2;
      held_use_rs1 <= ctrl.use_rs1;
      held_use_rs2 <= ctrl.use_rs2;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid) begin
      // stalled: keep operands coherent with writebacks landing behind us
      if (held_use_rs1 && wr_fire && wb_addr_i == held_rs1) rd1_o <= wb_data_i;
      if (held_use_rs2 && wr_fire && wb_addr_i == held_rs2) rd2_o <= wb_data_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
//==== tb_decode_stage: directed vector and sequence checks for decode_stage (rev 1.0) ====
module tb_decode_stage;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   instr = '0;
  logic [DW-1:0] pc = '0;
  logic          flush = 1'b0;
  logic          wb_en = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] pc_o, rd1_o, rd2_o, imm_o, a0_o;
  logic [AW-1:0] rd_addr_o;
  logic [3:0]    alu_ctrl_o;
  logic          alu_src_o, result_src_o, mem_write_o, reg_write_o;
  logic          branch_o, jump_o, jret_o, illegal_o;

  decode_stage #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .instr_i(instr), .pc_i(pc),
    .flush_i(flush),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_o(pc_o), .rd1_o(rd1_o), .rd2_o(rd2_o), .imm_o(imm_o),
    .rd_addr_o(rd_addr_o), .alu_ctrl_o(alu_ctrl_o),
    .alu_src_o(alu_src_o), .result_src_o(result_src_o), .mem_write_o(mem_write_o),
    .reg_write_o(reg_write_o), .branch_o(branch_o), .jump_o(jump_o), .jret_o(jret_o),
    .illegal_o(illegal_o), .a0_o(a0_o)
  );

  always #5 clk = ~clk;

  // {valid, pc, imm, rd, alu, src,res,mw,rw,br,j,jr,ill}
  logic [81:0] got;
  assign got = {out_valid, pc_o, imm_o, rd_addr_o, alu_ctrl_o,
                alu_src_o, result_src_o, mem_write_o, reg_write_o,
                branch_o, jump_o, jret_o, illegal_o};

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic [7:0]  flags;
  } vec_t;

  vec_t vecs [15];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'h00500093, 32'h00000005, 5'd1,  4'b0000, 8'b1001_0000}; // addi x1,x0,5
    vecs[1]  = '{32'h000101B3, 32'h00000000, 5'd3,  4'b0000, 8'b0001_0000}; // add x3,x2,x0
    vecs[2]  = '{32'h407302B3, 32'h00000000, 5'd5,  4'b1000, 8'b0001_0000}; // sub x5,x6,x7
    vecs[3]  = '{32'h40315093, 32'h00000403, 5'd1,  4'b1101, 8'b1001_0000}; // srai x1,x2,3
    vecs[4]  = '{32'hFFF27213, 32'hFFFFFFFF, 5'd4,  4'b0111, 8'b1001_0000}; // andi x4,x4,-1
    vecs[5]  = '{32'hFFC12303, 32'hFFFFFFFC, 5'd6,  4'b0000, 8'b1101_0000}; // lw x6,-4(x2)
    vecs[6]  = '{32'h00512423, 32'h00000008, 5'd8,  4'b0000, 8'b1010_0000}; // sw x5,8(x2)
    vecs[7]  = '{32'hFE208CE3, 32'hFFFFFFF8, 5'd25, 4'b1000, 8'b0000_1000}; // beq x1,x2,-8
    vecs[8]  = '{32'h001000EF, 32'h00000800, 5'd1,  4'b0000, 8'b1001_0100}; // jal x1,2048
    vecs[9]  = '{32'h00008067, 32'h00000000, 5'd0,  4'b0000, 8'b1001_0010}; // jalr x0,0(x1)
    vecs[10] = '{32'h800002B7, 32'h80000000, 5'd5,  4'b0000, 8'b1001_0000}; // lui x5,0x80000
    vecs[11] = '{32'h0000007F, 32'h00000000, 5'd0,  4'b0000, 8'b0000_0001}; // unknown opcode
    vecs[12] = '{32'h002088B3, 32'h00000000, 5'd17, 4'b0000, 8'b0000_0001}; // add x17,x1,x2
    vecs[13] = '{32'h000A2083, 32'h00000000, 5'd1,  4'b0000, 8'b1100_0001}; // lw x1,0(x20)
    vecs[14] = '{32'h01F02023, 32'h00000000, 5'd0,  4'b0000, 8'b1000_0001}; // sw x31,0(x0)

    // reset state
    repeat (2) tick;
    chk("reset_outs", got, '0);
    chk("reset_operands", {rd1_o, rd2_o, a0_o}, '0);
    chk("reset_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    // back-to-back decode vectors
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1;
      instr    = vecs[i].instr;
      pc       = 32'h1000 + 32'(4 * i);
      tick;
      chk($sformatf("vec%0d", i), got,
          {1'b1, pc, vecs[i].imm, vecs[i].rd, vecs[i].alu, vecs[i].flags});
    end
    in_valid = 1'b0;
    tick;
    chk("drain_valid", out_valid, 1'b0);

    // writeback bypass into capture
    in_valid = 1'b1; instr = 32'h000101B3; pc = 32'h2000;
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h1234;
    tick;
    wb_en = 1'b0;
    chk("bypass_rd1", {rd1_o, rd2_o}, {32'h1234, 32'h0});
    tick;
    chk("stored_rd1", rd1_o, 32'h1234);

    in_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'hA0A0;
    tick;
    chk("a0_value", a0_o, 32'hA0A0);
    wb_addr = 5'd0; wb_data = 32'hFFFF;
    tick;
    wb_en = 1'b0; in_valid = 1'b1; instr = 32'h000001B3; pc = 32'h2004;
    tick;
    chk("x0_reads_zero", rd1_o, 32'h0);

    // stall with writeback refresh
    instr = 32'h000101B3; pc = 32'h3000;
    tick;
    out_ready = 1'b0; instr = 32'h00500093; pc = 32'h3004;
    #1;
    chk("stall_in_ready", in_ready, 1'b0);
    tick;
    chk("stall_hold1", {got, rd1_o},
        {1'b1, 32'h3000, 32'h0, 5'd3, 4'b0000, 8'b0001_0000, 32'h1234});
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'hBEEF;
    tick;
    wb_en = 1'b0;
    chk("stall_refresh", rd1_o, 32'hBEEF);
    tick;
    chk("stall_hold3", {got, rd2_o},
        {1'b1, 32'h3000, 32'h0, 5'd3, 4'b0000, 8'b0001_0000, 32'h0});
    chk("stall_in_ready3", in_ready, 1'b0);
    out_ready = 1'b1; in_valid = 1'b0;
    tick;
    chk("release_valid", out_valid, 1'b0);

    // flush priority; writeback still lands
    in_valid = 1'b1; instr = 32'h000101B3; pc = 32'h4000;
    tick;
    flush = 1'b1; instr = 32'h00500093; pc = 32'h4004;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h55;
    #1;
    chk("flush_in_ready", in_ready, 1'b0);
    tick;
    flush = 1'b0; wb_en = 1'b0;
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_no_capture", pc_o, 32'h4000);
    instr = 32'h000281B3; pc = 32'h4008;
    tick;
    chk("flush_wb_done", {out_valid, pc_o, rd1_o}, {1'b1, 32'h4008, 32'h55});

    // asynchronous reset in the middle of a stall
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h77;
    instr = 32'h000081B3; pc = 32'h5000;
    tick;
    wb_en = 1'b0;
    chk("pre_reset_rd1", rd1_o, 32'h77);
    out_ready = 1'b0;
    tick;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_async_valid", out_valid, 1'b0);
    chk("reset_async_rd1", rd1_o, 32'h0);
    tick;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("reset_in_ready", in_ready, 1'b1);
    in_valid = 1'b1; instr = 32'h000081B3; pc = 32'h5004;
    tick;
    chk("reset_x1_cleared", {out_valid, rd1_o, a0_o}, {1'b1, 32'h0, 32'h0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
